// File: rtl/dct_pkg.sv
// Shared defaults, coefficient type and bank address helper for the DCT transpose buffer.
package dct_pkg;

    localparam int DCT_DW = 12;
    localparam int DCT_N  = 8;

    typedef logic signed [DCT_DW-1:0] coef_t;

    // Flat address of element (row, col) inside bank 0 or 1 of an n x n ping-pong store.
    function automatic logic [31:0] bank_addr(input logic        bank,
                                              input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int unsigned n);
        return ((32'(bank) * n + row) * n) + col;
    endfunction

endpackage

// File: rtl/dct_tbuf_ram.sv
// Simple dual-port RAM for the transpose buffer: sync write, sync read that holds when re=0.
// Only the read data register is reset; the array itself keeps its contents.
module dct_tbuf_ram #(
    parameter  int DW    = 12,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong NxN transpose buffer between the row and column DCT stages, valid/ready on both sides.
// Optional DCT_TRANSPOSE_BYPASS_EN adds row_mode to read blocks row-major (in-order block FIFO).
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int DW = DCT_DW,
    parameter int N  = DCT_N
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_first,
    output logic          dout_last
`ifdef DCT_TRANSPOSE_BYPASS_EN
    ,
    input  logic          row_mode
`endif
);

    localparam int LOG2N = $clog2(N);
    localparam int DEPTH = 2 * N * N;
    localparam int AW    = 2 * LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [1:0]       bank_full, bank_full_nxt;
    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_row, wr_col, rd_row, rd_col;
    logic             wr_fire, wr_last;
    logic             rd_en, rd_first, rd_last, rd_rowmaj;
    logic [AW-1:0]    waddr, raddr;

    assign din_ready = !bank_full[wr_bank];
    assign wr_fire   = din_valid && din_ready;
    assign wr_last   = (wr_row == LAST) && (wr_col == LAST);

    assign rd_en     = bank_full[rd_bank] && (!dout_valid || dout_ready);
    assign rd_first  = (rd_row == '0) && (rd_col == '0);
    assign rd_last   = (rd_row == LAST) && (rd_col == LAST);

    assign waddr = AW'(bank_addr(wr_bank, 32'(wr_row), 32'(wr_col), N));
    assign raddr = AW'(bank_addr(rd_bank, 32'(rd_row), 32'(rd_col), N));

`ifdef DCT_TRANSPOSE_BYPASS_EN
    logic mode_q;

    // The first read of a block uses row_mode live; later reads use the captured copy.
    assign rd_rowmaj = rd_first ? row_mode : mode_q;

    always_ff @(posedge CLK) begin
        if (!RST)
            mode_q <= 1'b0;
        else if (rd_en && rd_first)
            mode_q <= row_mode;
    end
`else
    assign rd_rowmaj = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_row  <= '0;
            wr_col  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            wr_col <= wr_col + LOG2N'(1);
            if (wr_col == LAST)
                wr_row <= wr_row + LOG2N'(1);
            if (wr_last)
                wr_bank <= !wr_bank;
        end
    end

    // Transposed readout walks down a column first; counters wrap back to zero at the block end.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_row  <= '0;
            rd_col  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_en) begin
            if (rd_rowmaj) begin
                rd_col <= rd_col + LOG2N'(1);
                if (rd_col == LAST)
                    rd_row <= rd_row + LOG2N'(1);
            end else begin
                rd_row <= rd_row + LOG2N'(1);
                if (rd_row == LAST)
                    rd_col <= rd_col + LOG2N'(1);
            end
            if (rd_last)
                rd_bank <= !rd_bank;
        end
    end

    // Fill and drain always target different banks, so set and clear never collide.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_fire && wr_last)
            bank_full_nxt[wr_bank] = 1'b1;
        if (rd_en && rd_last)
            bank_full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST)
            bank_full <= 2'b00;
        else
            bank_full <= bank_full_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else if (rd_en) begin
            dout_valid <= 1'b1;
            dout_first <= rd_first;
            dout_last  <= rd_last;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

    dct_tbuf_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RST),
        .we    (wr_fire),
        .waddr (waddr),
        .wdata (din),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Bench for dct_transpose_buf: queue-based block transpose model plus directed literal checks.
module tb_dct_transpose_buf;
    import dct_pkg::*;

    localparam int N  = 8;
    localparam int NN = N * N;
    localparam int DW = 12;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic [DW-1:0] din, dout;
    logic din_valid, din_ready, dout_valid, dout_ready, dout_first, dout_last;
    logic row_mode = 1'b0;

    logic [15:0] din4, dout4;
    logic din_valid4 = 1'b0, din_ready4, dout_valid4, dout_ready4 = 1'b1, dout_first4, dout_last4;

    dct_transpose_buf #(.DW(DW), .N(N)) dut (
        .CLK(CLK), .RST(RST), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_first(dout_first), .dout_last(dout_last)
`ifdef DCT_TRANSPOSE_BYPASS_EN
        , .row_mode(row_mode)
`endif
    );

    dct_transpose_buf #(.DW(16), .N(4)) dut4 (
        .CLK(CLK), .RST(RST), .din(din4), .din_valid(din_valid4), .din_ready(din_ready4),
        .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4),
        .dout_first(dout_first4), .dout_last(dout_last4)
`ifdef DCT_TRANSPOSE_BYPASS_EN
        , .row_mode(1'b0)
`endif
    );

    typedef struct { logic [DW-1:0] d; logic f; logic l; } exp_t;

    int errors = 0, checks = 0, cyc = 0;
    int acc_cnt = 0, outs = 0, notrdy_cnt = 0;
    int last_acc_cyc = 0, first_vld_cyc = 0;
    int vld_pct = 100, rdy_pct = 100;
    bit mode_rm = 1'b0;
    exp_t exp_q[$];
    logic [DW-1:0] blk[$], in_q[$], out_log[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Reference: collect N*N accepted words, then queue them in column-major (or row-major) order.
    initial begin : cmp
        exp_t e;
        logic prev_vld, hold_pend;
        logic [DW-1:0] hold_d;
        logic hold_f, hold_l;
        prev_vld = 0; hold_pend = 0; hold_d = '0; hold_f = 0; hold_l = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                exp_q.delete(); blk.delete();
                hold_pend = 0; prev_vld = 0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", dout_valid, 1);
                    chk("hold_dout", dout, hold_d);
                    chk("hold_flags", {dout_first, dout_last}, {hold_f, hold_l});
                end
                if (dout_valid && !prev_vld) first_vld_cyc = cyc;
                prev_vld = dout_valid;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_output: got %0d, want no output", dout);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout", dout, e.d);
                        chk("dout_first", dout_first, e.f);
                        chk("dout_last", dout_last, e.l);
                    end
                    out_log.push_back(dout);
                    outs++;
                end
                hold_pend = dout_valid && !dout_ready;
                hold_d = dout; hold_f = dout_first; hold_l = dout_last;
                if (din_valid && !din_ready) notrdy_cnt++;
                if (din_valid && din_ready) begin
                    acc_cnt++;
                    blk.push_back(din);
                    if (blk.size() == NN) begin
                        last_acc_cyc = cyc;
                        for (int i = 0; i < NN; i++) begin
                            int src;
                            src = mode_rm ? i : (i % N) * N + i / N;
                            exp_q.push_back('{blk[src], i == 0, i == NN - 1});
                        end
                        blk.delete();
                    end
                end
            end
        end
    end

    initial begin : drv
        bit acc;
        din = '0; din_valid = 0; dout_ready = 0;
        forever begin
            @(negedge CLK);
            acc = din_valid && din_ready && RST;
            @(posedge CLK);
            #1;
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() == 0) din_valid = 0;
            else if (!din_valid || acc) begin
                din_valid = ($urandom_range(99) < vld_pct);
                din = in_q[0];
            end
            dout_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic wait_outs(input string name, input int target, input int limit);
        int n = 0;
        while (outs < target && n < limit) begin
            @(posedge CLK);
            n++;
        end
        chk(name, outs, target);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        in_q.delete();
        #1 RST = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_first", dout_first, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_dout", dout, 0);
        @(posedge CLK);
        #1 RST = 1;
        @(negedge CLK);
        chk("rst_din_ready", din_ready, 1);
    endtask

    initial begin : wdog
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ob, a0, nr0, c0, c1, c_last, c_rdy, n;
        int exp4[16];
        logic [15:0] got4[$];
        logic f4[$], l4[$];
        din4 = '0;

        // Reset / transpose order and latency
        do_reset();
        @(posedge CLK);
        ob = out_log.size();
        for (int i = 0; i < NN; i++) in_q.push_back(DW'(i));
        wait_outs("t1_count", ob + NN, 400);
        chk("t1_latency", first_vld_cyc - last_acc_cyc, 2);
        chk("t1_out0", out_log[ob + 0], 0);
        chk("t1_out1", out_log[ob + 1], 8);
        chk("t1_out7", out_log[ob + 7], 56);
        chk("t1_out8", out_log[ob + 8], 1);
        chk("t1_out63", out_log[ob + 63], 63);

        // Full rate: 4 blocks, no stalls either side
        ob = outs; nr0 = notrdy_cnt;
        for (int i = 0; i < 4 * NN; i++) in_q.push_back(DW'(i * 7 + 3));
        n = 0;
        while (outs < ob + 1 && n < 500) begin @(posedge CLK); n++; end
        c0 = cyc;
        while (outs < ob + 4 * NN && n < 1000) begin @(posedge CLK); n++; end
        c1 = cyc;
        chk("t2_count", outs, ob + 4 * NN);
        chk("t2_no_bubbles", c1 - c0, 4 * NN - 1);
        chk("t2_din_ready_stall", notrdy_cnt - nr0, 0);

        // Backpressure: two banks fill, then writer stalls
        @(posedge CLK);
        rdy_pct = 0;
        repeat (3) @(posedge CLK);
        ob = outs; a0 = acc_cnt;
        for (int i = 0; i < 3 * NN; i++) in_q.push_back(DW'(i % NN));
        repeat (250) @(posedge CLK);
        chk("t3_accepted", acc_cnt - a0, 2 * NN);
        @(negedge CLK);
        chk("t3_din_ready", din_ready, 0);
        chk("t3_dout_valid", dout_valid, 1);
        chk("t3_dout_held", dout, 0);
        rdy_pct = 100;
        c_last = -1; c_rdy = -1; n = 0;
        while ((c_last < 0 || c_rdy < 0) && n < 200) begin
            @(negedge CLK);
            if (c_last < 0 && dout_valid && dout_last) c_last = cyc;
            if (c_rdy < 0 && din_ready) c_rdy = cyc;
            n++;
        end
        chk("t3_ready_return", c_rdy, c_last);
        wait_outs("t3_count", ob + 3 * NN, 600);

        // Random stalls on both sides over 20 blocks
        vld_pct = 50; rdy_pct = 50;
        a0 = acc_cnt; ob = outs;
        for (int i = 0; i < 20 * NN; i++) in_q.push_back(DW'($urandom_range(4095)));
        wait_outs("t4_count", ob + 20 * NN, 20000);
        chk("t4_accepted", acc_cnt - a0, 20 * NN);
        chk("t4_model_empty", exp_q.size(), 0);

        // Reset 30 words into the second block
        vld_pct = 100; rdy_pct = 100;
        a0 = acc_cnt;
        for (int i = 0; i < NN + 30; i++) in_q.push_back(DW'(i + 100));
        n = 0;
        while (acc_cnt < a0 + NN + 30 && n < 500) begin @(posedge CLK); n++; end
        chk("t5_pre_accepted", acc_cnt - a0, NN + 30);
        do_reset();
        @(posedge CLK);
        ob = outs;
        for (int i = 0; i < NN; i++) in_q.push_back(DW'(i));
        wait_outs("t5_count", ob + NN, 400);
        chk("t5_out0", out_log[ob], 0);
        chk("t5_out1", out_log[ob + 1], 8);
        chk("t5_out63", out_log[ob + 63], 63);

`ifdef DCT_TRANSPOSE_BYPASS_EN
        @(posedge CLK);
        row_mode = 1; mode_rm = 1;
        ob = outs;
        for (int i = 0; i < NN; i++) in_q.push_back(DW'(i));
        wait_outs("byp_count", ob + NN, 400);
        chk("byp_out1", out_log[ob + 1], 1);
        chk("byp_out8", out_log[ob + 8], 8);
        chk("byp_out63", out_log[ob + 63], 63);
        @(posedge CLK);
        row_mode = 0; mode_rm = 0;
`endif

        // N=4, DW=16 instance
        exp4 = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK);
            #1 din4 = 16'(i); din_valid4 = 1;
            @(negedge CLK);
            chk("n4_din_ready", din_ready4, 1);
        end
        @(posedge CLK);
        #1 din_valid4 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (dout_valid4) begin
                got4.push_back(dout4); f4.push_back(dout_first4); l4.push_back(dout_last4);
            end
        end
        chk("n4_count", got4.size(), 16);
        if (got4.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("n4_dout", got4[i], exp4[i]);
            chk("n4_first", {f4[0], f4[1]}, 2'b10);
            chk("n4_last", {l4[14], l4[15]}, 2'b01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
